// File: rtl/branch_ctrl_bht_if.sv
// Decode/fetch-side bundle between the pipeline and the branch resolver/predictor.
// The master is the pipeline; the slave is branch_ctrl_bht.
interface branch_ctrl_bht_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] fetch_pc;
  logic             pred_taken;
  logic             dec_valid;
  logic [15:0]      dec_instr;
  logic [WIDTH-1:0] dec_pc;
  logic [WIDTH-1:0] dec_rs;
  logic             dec_pred_taken;
  logic             stall;
  logic             pc_sel;
  logic             is_bj;
  logic             is_cond;
  logic             mispredict;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  modport master (
    output fetch_pc, dec_valid, dec_instr, dec_pc, dec_rs, dec_pred_taken, stall,
    input  pred_taken, pc_sel, is_bj, is_cond, mispredict, br_cnt, mp_cnt
  );

  modport slave (
    input  fetch_pc, dec_valid, dec_instr, dec_pc, dec_rs, dec_pred_taken, stall,
    output pred_taken, pc_sel, is_bj, is_cond, mispredict, br_cnt, mp_cnt
  );
endinterface

// File: rtl/branch_ctrl_bht.sv
// Decode-stage branch/jump resolver with a PC-indexed 2-bit BHT and saturating
// branch/mispredict counters.
//
// BHT entry state | meaning
// ----------------+----------------
// 2'b00           | strong not-taken
// 2'b01           | weak not-taken (reset value)
// 2'b10           | weak taken
// 2'b11           | strong taken
module branch_ctrl_bht #(
  parameter int WIDTH   = 16,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 16,
  parameter int PRED_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  branch_ctrl_bht_if.slave  bus
);
  localparam int         DEPTH   = 2 ** IDX_W;
  localparam logic [1:0] WEAK_NT = 2'b01;

  logic [1:0]       bht [DEPTH];
  logic [4:0]       opcode;
  logic             is_cond_op;
  logic             is_jump_op;
  logic             taken;
  logic             upd_en;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] dec_idx;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;
  logic             unused_pc_bits;

  always_comb begin
    opcode     = bus.dec_instr[15:11];
    is_cond_op = 1'b0;
    is_jump_op = 1'b0;
    taken      = 1'b0;
    casez (opcode)
      5'b01100: begin is_cond_op = 1'b1; taken = (bus.dec_rs == '0);    end
      5'b01101: begin is_cond_op = 1'b1; taken = (bus.dec_rs != '0);    end
      5'b01110: begin is_cond_op = 1'b1; taken =  bus.dec_rs[WIDTH-1];  end
      5'b01111: begin is_cond_op = 1'b1; taken = ~bus.dec_rs[WIDTH-1];  end
      5'b001??: is_jump_op = 1'b1;
      default:  ;
    endcase
  end

  assign bus.is_cond    = bus.dec_valid & is_cond_op;
  assign bus.is_bj      = bus.dec_valid & (is_cond_op | is_jump_op);
  assign bus.pc_sel     = bus.dec_valid & (is_jump_op | (is_cond_op & taken));
  assign bus.mispredict = bus.is_cond & (taken != bus.dec_pred_taken) & ~rst;

  // Reset has priority in the sequential blocks, so it is not folded in here.
  assign upd_en = bus.is_cond & ~bus.stall;

  // Instructions are halfword aligned, so PC bit 0 never selects an entry.
  assign fetch_idx = bus.fetch_pc[IDX_W:1];
  assign dec_idx   = bus.dec_pc[IDX_W:1];
  assign unused_pc_bits = ^{bus.fetch_pc[WIDTH-1:IDX_W+1], bus.fetch_pc[0],
                            bus.dec_pc[WIDTH-1:IDX_W+1], bus.dec_pc[0]};

  assign bus.pred_taken = (PRED_EN != 0) && bht[fetch_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= WEAK_NT;
    end else if (upd_en && (PRED_EN != 0)) begin
      if (taken) begin
        if (bht[dec_idx] != 2'b11) bht[dec_idx] <= bht[dec_idx] + 2'd1;
      end else begin
        if (bht[dec_idx] != 2'b00) bht[dec_idx] <= bht[dec_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (upd_en) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
      if (bus.mispredict && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + 1'b1;
    end
  end

  assign bus.br_cnt = br_cnt_q;
  assign bus.mp_cnt = mp_cnt_q;
endmodule
